// File: rtl/dm_resp_if.sv
// Processor <-> data-memory request/acknowledge bus.
interface dm_resp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (output req, we, addr, wdata, input ack, err, rdata, busy);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata, busy);
endinterface

// File: rtl/dm_resp.sv
// Handshaked data-memory responder: word storage behind a fixed number of
// wait states, one-cycle ack carrying read data (or echoed write data) and
// an out-of-range error flag.
module dm_resp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic    clk,
  input logic    rst,
  dm_resp_if.slave bus
);
  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  // Operand source: with zero wait states the response is produced on the
  // capture edge itself, so the live inputs are used; otherwise the captured copy.
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              go_resp;

  assign op_we    = (state == S_IDLE) ? bus.we    : cap_we;
  assign op_addr  = (state == S_IDLE) ? bus.addr  : cap_addr;
  assign op_wdata = (state == S_IDLE) ? bus.wdata : cap_wdata;
  // Full-width unsigned compare; the index is only meaningful once in range.
  assign in_range = 32'(op_addr) < DEPTH_U;
  assign idx      = op_addr[IDX_W-1:0];
  // Edge that enters RESP; gated by rst so a pending write is dropped.
  assign go_resp  = !rst && (((state == S_IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                             ((state == S_WAIT) && (cnt == 4'd0)));

  assign bus.busy = (state != S_IDLE);

  // Storage write; array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (go_resp && in_range && op_we) mem[idx] <= op_wdata;
  end

  // Request FSM with registered ack/err/rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            cap_we    <= bus.we;
            cap_addr  <= bus.addr;
            cap_wdata <= bus.wdata;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          state   <= S_IDLE;
          bus.ack <= 1'b0;
          bus.err <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        bus.ack <= 1'b1;
        if (in_range) begin
          bus.err   <= 1'b0;
          bus.rdata <= op_we ? op_wdata : mem[idx];
        end else begin
          bus.err   <= 1'b1;
          bus.rdata <= '0;
        end
      end
    end
  end
endmodule
